// File: rtl/event_drain_ctrl.sv
// event_drain_ctrl: register-bus master that arms event_monitor_top, polls its
// STATUS register, drains each captured event (ID, DATA, TS) out of the monitor
// FIFO and presents it to a log sink on a valid/ready stream.
module event_drain_ctrl #(
  parameter int          PROBE_W       = 32,
  parameter int          ID_W          = 8,
  parameter int          TS_W          = 32,
  parameter int          RD_LAT        = 1,
  parameter int          POLL_GAP      = 8,
  parameter logic [7:0]  ADDR_CONTROL  = 8'h00,
  parameter logic [7:0]  ADDR_STATUS   = 8'h0C,
  parameter logic [7:0]  ADDR_EVT_ID   = 8'h10,
  parameter logic [7:0]  ADDR_EVT_DATA = 8'h14,
  parameter logic [7:0]  ADDR_EVT_TS   = 8'h18,
  parameter logic [7:0]  ADDR_EVT_POP  = 8'h1C
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic [31:0]        arm_word,
  output logic               bus_wr,
  output logic               bus_rd,
  output logic [7:0]         bus_addr,
  output logic [31:0]        bus_wdata,
  input  logic [31:0]        bus_rdata,
  output logic               ev_valid,
  input  logic               ev_ready,
  output logic [ID_W-1:0]    ev_id,
  output logic [PROBE_W-1:0] ev_data,
  output logic [TS_W-1:0]    ev_ts,
  output logic               busy,
  output logic               overflow_seen,
  output logic [15:0]        ev_count
);

  localparam int WAIT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam int GAP_W  = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RD_LAT - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(POLL_GAP - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_ARM, S_POLL, S_RWAIT, S_CLR_OVF, S_RD_ID,
    S_RD_DATA, S_RD_TS, S_POP, S_PRESENT, S_GAP
  } state_e;

  // Which register the outstanding read targets, so RWAIT knows where to go next.
  typedef enum logic [1:0] {RK_STATUS, RK_ID, RK_DATA, RK_TS} rd_kind_e;

  state_e             state_q, state_d;
  rd_kind_e           kind_q, kind_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               stop_q, stop_d;      // stop request waiting for an event boundary
  logic               ovf_q, ovf_d;
  logic               ne_q, ne_d;          // FIFO was non-empty in the poll that saw overflow
  logic [15:0]        count_q, count_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [PROBE_W-1:0] data_q, data_d;
  logic [TS_W-1:0]    ts_q, ts_d;
  logic [7:0]         addr_q;              // address/wdata hold their value between commands
  logic [31:0]        wdata_q;
  logic               stop_now;

  assign stop_now      = stop_q | stop;
  assign ev_valid      = (state_q == S_PRESENT);
  assign busy          = (state_q != S_IDLE);
  assign overflow_seen = ovf_q;
  assign ev_count      = count_q;
  assign ev_id         = id_q;
  assign ev_data       = data_q;
  assign ev_ts         = ts_q;

  // Next-state, bus command and capture logic.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    kind_d    = kind_q;
    wait_d    = wait_q;
    gap_d     = gap_q;
    stop_d    = stop_q;
    ovf_d     = ovf_q;
    ne_d      = ne_q;
    count_d   = count_q;
    id_d      = id_q;
    data_d    = data_q;
    ts_d      = ts_q;
    bus_wr    = 1'b0;
    bus_rd    = 1'b0;
    bus_addr  = addr_q;
    bus_wdata = wdata_q;

    if (stop && state_q != S_IDLE) stop_d = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        stop_d = 1'b0;
        // stop in the same cycle as start keeps the block idle
        if (start && !stop) begin
          state_d = S_ARM;
          ovf_d   = 1'b0;
          count_d = '0;
        end
      end
      S_ARM: begin
        bus_wr    = 1'b1;
        bus_addr  = ADDR_CONTROL;
        bus_wdata = arm_word;
        state_d   = S_POLL;
      end
      S_POLL: begin
        if (stop_q) begin
          state_d = S_IDLE;
          stop_d  = 1'b0;
        end else begin
          bus_rd   = 1'b1;
          bus_addr = ADDR_STATUS;
          kind_d   = RK_STATUS;
          wait_d   = '0;
          state_d  = S_RWAIT;
        end
      end
      S_RWAIT: begin
        wait_d = wait_q + 1'b1;
        if (wait_q == WAIT_LAST) begin
          wait_d = '0;
          unique case (kind_q)
            RK_STATUS: begin
              if (bus_rdata[2]) begin
                state_d = S_CLR_OVF;
                ne_d    = bus_rdata[1];
              end else if (bus_rdata[1]) begin
                state_d = S_RD_ID;
              end else begin
                state_d = S_GAP;
                gap_d   = '0;
              end
            end
            RK_ID: begin
              id_d    = bus_rdata[ID_W-1:0];
              state_d = S_RD_DATA;
            end
            RK_DATA: begin
              data_d  = bus_rdata[PROBE_W-1:0];
              state_d = S_RD_TS;
            end
            RK_TS: begin
              ts_d    = bus_rdata[TS_W-1:0];
              state_d = S_POP;
            end
            default: state_d = S_IDLE;
          endcase
        end
      end
      S_CLR_OVF: begin
        bus_wr    = 1'b1;
        bus_addr  = ADDR_STATUS;
        bus_wdata = 32'h4;
        ovf_d     = 1'b1;
        if (ne_q) begin
          state_d = S_RD_ID;
        end else begin
          state_d = S_GAP;
          gap_d   = '0;
        end
      end
      S_RD_ID, S_RD_DATA, S_RD_TS: begin
        bus_rd  = 1'b1;
        wait_d  = '0;
        state_d = S_RWAIT;
        if (state_q == S_RD_ID) begin
          bus_addr = ADDR_EVT_ID;
          kind_d   = RK_ID;
        end else if (state_q == S_RD_DATA) begin
          bus_addr = ADDR_EVT_DATA;
          kind_d   = RK_DATA;
        end else begin
          bus_addr = ADDR_EVT_TS;
          kind_d   = RK_TS;
        end
      end
      S_POP: begin
        bus_wr    = 1'b1;
        bus_addr  = ADDR_EVT_POP;
        bus_wdata = 32'h0;
        state_d   = S_PRESENT;
      end
      S_PRESENT: begin
        if (ev_ready) begin
          if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
          if (stop_now) begin
            state_d = S_IDLE;
            stop_d  = 1'b0;
          end else begin
            state_d = S_POLL;
          end
        end
      end
      S_GAP: begin
        if (stop_now) begin
          state_d = S_IDLE;
          stop_d  = 1'b0;
        end else if (gap_q == GAP_LAST) begin
          state_d = S_POLL;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any outstanding read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the captured event fields are reset too, so every output reads 0
      // straight out of reset rather than showing a stale event.
      state_q <= S_IDLE;
      kind_q  <= RK_STATUS;
      wait_q  <= '0;
      gap_q   <= '0;
      stop_q  <= 1'b0;
      ovf_q   <= 1'b0;
      ne_q    <= 1'b0;
      count_q <= '0;
      id_q    <= '0;
      data_q  <= '0;
      ts_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      kind_q  <= kind_d;
      wait_q  <= wait_d;
      gap_q   <= gap_d;
      stop_q  <= stop_d;
      ovf_q   <= ovf_d;
      ne_q    <= ne_d;
      count_q <= count_d;
      id_q    <= id_d;
      data_q  <= data_d;
      ts_q    <= ts_d;
      addr_q  <= bus_addr;
      wdata_q <= bus_wdata;
    end
  end

endmodule
